lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit between the execute stage and the data memory port (word-addressed, no byte enables).
- Accepts one load/store request at a time and performs word-aligned accesses.
- Handles sub-word stores by read-modify-write; sign-/zero-extends loads.
- Checks alignment and bounds the wait for memory valid with a timeout.

Parameters:
- WAIT_MAX, 16, maximum cycles to wait for mem_valid in any memory state before aborting with an error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle pulse when the request completes
- resp_err  output  1  qualifies resp_valid: misaligned access, illegal funct3, or timeout
- resp_rdata  output  32  extended load data; 0 for stores and errors
- mem_addr  output  32  word index = {2'b00, req_addr[31:2]}
- mem_write  output  1  memory write strobe
- mem_write_data  output  32  full word to write
- mem_data  input  32  memory read word
- mem_valid  input  1  memory data/write accepted this cycle

Behaviour:
- All outputs are registered; no combinational path from req_* to mem_*.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_write=0, mem_write_data=0. State=IDLE, wait counter=0.
- States: IDLE, RD, WR, RESP.
- IDLE: on req_valid, latch the request and leave IDLE; req_ready drops the next cycle.
  - Illegal funct3 (load 3/6/7; store ≥3), or misaligned (half with addr[0]=1, word with addr[1:0]≠0) → RESP with err. No mem_write is ever issued.
  - Load, or SB/SH → RD. SW → WR with mem_write_data=req_wdata.
- mem_addr is driven from the latched address in RD/WR and holds its last value otherwise.
- RD: mem_write=0. On mem_valid, capture mem_data.
  - Load → RESP.
  - SB/SH → WR with the merged word: the captured word with bytes replaced at lane addr[1:0] (SB) or half addr[1] (SH), taken from req_wdata[7:0] / [15:0].
- WR: mem_write=1 with stable mem_addr and mem_write_data. On mem_valid, mem_write clears and the state goes to RESP.
  - mem_write is high for exactly one cycle when mem_valid is tied high.
- RESP: resp_valid=1 for one cycle, then IDLE with req_ready=1.
  - Loads: extract the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency from the accept edge to resp_valid with mem_valid tied high:
  - errors: 1 cycle
  - LW / LB / LH: 2 cycles
  - SW: 2 cycles
  - SB / SH: 3 cycles
- Timeout: the counter resets on entering RD/WR and increments each cycle without mem_valid. At WAIT_MAX it goes to RESP with err, mem_write forced to 0, and no partial write of merged data.
- req_valid while not in IDLE is ignored (req_ready=0); the requester holds.
- Asynchronous reset mid-operation: immediate return to IDLE and reset values, including mem_write=0. The aborted request produces no response.
- Back-to-back: a new request may be accepted in the cycle after RESP.

Test Plan:
- LW addr 0x10, mem word[4]=0xDEADBEEF → mem_addr=4, resp_rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after accept.
- LB addr 0x13, word=0x80112233 → rdata=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x12 → 0x00008011.
- SB addr 0x21, wdata=0x000000AB, word[8]=0x11223344 → one mem_write pulse, mem_write_data=0x1122AB44, response 3 cycles after accept.
- SH addr 0x03 → resp_err=1 one cycle after accept, mem_write never asserted; illegal funct3=3 load → err=1.
- mem_valid held low for 16 cycles in WR → resp_err=1, mem_write deasserts, memory unchanged.
- rst_n asserted during the WR of an SB → mem_write drops asynchronously, no resp_valid; next LW accepted normally.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Request/response and data-memory bus bundle for lsu_mem_port.
// Ports (signals):
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : execute-stage request
//   resp_valid/resp_err/resp_rdata                              : completion response
//   mem_addr/mem_write/mem_write_data/mem_data/mem_valid        : word-addressed memory port
// Modports: slave = the load/store unit, master = the execute stage plus memory side.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_data;
  logic        mem_valid;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data, mem_valid,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_write, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data, mem_valid,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_write, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: one request at a time, word-aligned memory accesses,
// read-modify-write for SB/SH, sign/zero extension for loads, and a bounded
// wait on mem_valid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_mem_port_if.slave (request, response and memory signals)
module lsu_mem_port #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_port_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             illegal_c, misalign_c;

  // Lane extraction and extension of a captured word for a load.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd1:    load_ext = {{16{h[15]}}, h};
      3'd4:    load_ext = {24'd0, b};
      3'd5:    load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Replace the addressed byte (SB) or half (SH) of the read word.
  function automatic logic [31:0] store_merge(input logic f3_half, input logic [1:0] off,
                                              input logic [31:0] w, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (f3_half) begin
      if (off[1]) m[31:16] = d;
      else        m[15:0]  = d;
    end else begin
      case (off)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end
    store_merge = m;
  endfunction

  // Request legality, evaluated on the incoming request.
  always_comb begin
    if (bus.req_write) illegal_c = (bus.req_funct3 >= 3'd3);
    else               illegal_c = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                                   (bus.req_funct3 == 3'd7);
    misalign_c = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                 ((bus.req_funct3 == 3'd2) && (bus.req_addr[1:0] != 2'd0));
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata[15:0];
          err_d   = illegal_c || misalign_c;
          cnt_d   = '0;
          if (illegal_c || misalign_c) begin
            state_d = RESP;
          end else if (bus.req_write && (bus.req_funct3 == 3'd2)) begin
            state_d     = WR;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (bus.mem_valid) begin
          rdata_d = bus.mem_data;
          if (write_q) begin
            state_d     = WR;
            cnt_d       = '0;
            mem_wdata_d = store_merge(f3_q[0], addr_q[1:0], bus.mem_data, wdata_q);
          end else begin
            state_d = RESP;
          end
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        if (bus.mem_valid) begin
          state_d = RESP;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (err_q || write_q) ? 32'd0 : load_ext(f3_q, addr_q[1:0], rdata_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs that depend only on where the FSM is heading.
    req_ready_d = (state_d == IDLE);
    mem_write_d = (state_d == WR);
    if ((state_d == RD) || (state_d == WR)) mem_addr_d = {2'b00, addr_d[31:2]};
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 16'd0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed, table-driven bench for lsu_mem_port with a small word memory.
module tb_lsu_mem_port;

  logic clk;
  logic rst_n;
  logic mv_en;
  logic [31:0] mem [64];
  int checks;
  int failures;

  lsu_mem_port_if bus();

  lsu_mem_port #(.WAIT_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.mem_data  = mem[bus.mem_addr[5:0]];
  assign bus.mem_valid = mv_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge and return at the negedge where resp_valid is seen.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int nwr);
    bit done;
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    lat  = 0;
    nwr  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (lat == 0) chk("req_ready_drop", 32'(bus.req_ready), 32'd0);
      if (bus.mem_write) begin
        nwr++;
        if (bus.mem_valid) mem[bus.mem_addr[5:0]] = bus.mem_write_data;
      end
      if (bus.resp_valid) done = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL resp_wait actual=no_resp required=resp_valid addr=0x%08h", addr);
    end
  endtask

  initial begin
    int lat;
    int nwr;
    bit seen;
    checks   = 0;
    failures = 0;
    mv_en    = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    //        wr    f3    addr          wdata         init          exp_rd        err  lat nwr exp_mem
    vecs[0]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'h80112233, 32'hFFFFFF80, 1'b0, 2, 0, 32'h80112233};
    vecs[2]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h80112233, 32'h00000080, 1'b0, 2, 0, 32'h80112233};
    vecs[3]  = '{1'b0, 3'd5, 32'h12, 32'h0,        32'h80112233, 32'h00008011, 1'b0, 2, 0, 32'h80112233};
    vecs[4]  = '{1'b0, 3'd1, 32'h12, 32'h0,        32'h80112233, 32'hFFFF8011, 1'b0, 2, 0, 32'h80112233};
    vecs[5]  = '{1'b0, 3'd0, 32'h10, 32'h0,        32'h80112233, 32'h00000033, 1'b0, 2, 0, 32'h80112233};
    vecs[6]  = '{1'b0, 3'd1, 32'h10, 32'h0,        32'h80112233, 32'h00002233, 1'b0, 2, 0, 32'h80112233};
    vecs[7]  = '{1'b0, 3'd4, 32'h31, 32'h0,        32'h0000FF00, 32'h000000FF, 1'b0, 2, 0, 32'h0000FF00};
    vecs[8]  = '{1'b0, 3'd0, 32'h31, 32'h0,        32'h0000FF00, 32'hFFFFFFFF, 1'b0, 2, 0, 32'h0000FF00};
    vecs[9]  = '{1'b1, 3'd0, 32'h21, 32'h000000AB, 32'h11223344, 32'h0,        1'b0, 3, 1, 32'h1122AB44};
    vecs[10] = '{1'b1, 3'd1, 32'h22, 32'h1234CAFE, 32'h11223344, 32'h0,        1'b0, 3, 1, 32'hCAFE3344};
    vecs[11] = '{1'b1, 3'd2, 32'h24, 32'hA5A55A5A, 32'h00000000, 32'h0,        1'b0, 2, 1, 32'hA5A55A5A};
    vecs[12] = '{1'b1, 3'd1, 32'h03, 32'h0000BEEF, 32'h55667788, 32'h0,        1'b1, 1, 0, 32'h55667788};
    vecs[13] = '{1'b0, 3'd3, 32'h28, 32'h0,        32'h01020304, 32'h0,        1'b1, 1, 0, 32'h01020304};
    vecs[14] = '{1'b0, 3'd2, 32'h2A, 32'h0,        32'h01020304, 32'h0,        1'b1, 1, 0, 32'h01020304};
    vecs[15] = '{1'b1, 3'd4, 32'h30, 32'h000000FF, 32'h0A0B0C0D, 32'h0,        1'b1, 1, 0, 32'h0A0B0C0D};
    vecs[16] = '{1'b0, 3'd5, 32'h31, 32'h0,        32'h0A0B0C0D, 32'h0,        1'b1, 1, 0, 32'h0A0B0C0D};

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_mem_addr",   bus.mem_addr,        32'd0);
    chk("rst_mem_write",  32'(bus.mem_write),  32'd0);
    chk("rst_mem_wdata",  bus.mem_write_data,  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back.
    for (int i = 0; i < NV; i++) begin
      mem[vecs[i].addr[7:2]] = vecs[i].init;
      run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, nwr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_err", i), 32'(bus.resp_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdata", i), bus.resp_rdata, vecs[i].exp_rd);
      chk($sformatf("v%0d_nwrite", i), 32'(nwr), 32'(vecs[i].exp_nwr));
      chk($sformatf("v%0d_mem", i), mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
      chk($sformatf("v%0d_ready_at_resp", i), 32'(bus.req_ready), 32'd1);
      if (!vecs[i].exp_err) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, {2'b00, vecs[i].addr[31:2]});
    end

    // SW timeout: mem_valid low throughout WR.
    mem[14] = 32'hCAFEF00D;
    mv_en = 1'b0;
    run_req(1'b1, 3'd2, 32'h38, 32'h12345678, lat, nwr);
    chk("to_sw_latency", 32'(lat), 32'd17);
    chk("to_sw_err", 32'(bus.resp_err), 32'd1);
    chk("to_sw_rdata", bus.resp_rdata, 32'd0);
    chk("to_sw_nwrite_cycles", 32'(nwr), 32'd16);
    chk("to_sw_mem_write_low", 32'(bus.mem_write), 32'd0);
    chk("to_sw_mem", mem[14], 32'hCAFEF00D);

    // LW timeout in RD.
    run_req(1'b0, 3'd2, 32'h3C, 32'h0, lat, nwr);
    chk("to_lw_latency", 32'(lat), 32'd17);
    chk("to_lw_err", 32'(bus.resp_err), 32'd1);
    chk("to_lw_rdata", bus.resp_rdata, 32'd0);

    // SB timeout in RD: no write may be issued.
    mem[15] = 32'h99887766;
    run_req(1'b1, 3'd0, 32'h3D, 32'h55, lat, nwr);
    chk("to_sb_latency", 32'(lat), 32'd17);
    chk("to_sb_err", 32'(bus.resp_err), 32'd1);
    chk("to_sb_nwrite", 32'(nwr), 32'd0);
    chk("to_sb_mem", mem[15], 32'h99887766);
    mv_en = 1'b1;

    // Reset during the WR phase of an SB.
    mem[16] = 32'h11223344;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h41;
    bus.req_wdata  = 32'hEE;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr_mem_write_high", 32'(bus.mem_write), 32'd1);
    chk("rst_wr_merged_data", bus.mem_write_data, 32'h1122EE44);
    mv_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_mem_write_drop", 32'(bus.mem_write), 32'd0);
    chk("rst_wr_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mv_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_write) seen = 1'b1;
    end
    chk("rst_wr_no_resp", 32'(seen), 32'd0);
    chk("rst_wr_mem", mem[16], 32'h11223344);
    run_req(1'b0, 3'd2, 32'h40, 32'h0, lat, nwr);
    chk("post_rst_lw_latency", 32'(lat), 32'd2);
    chk("post_rst_lw_err", 32'(bus.resp_err), 32'd0);
    chk("post_rst_lw_rdata", bus.resp_rdata, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound in case a wait escapes its own budget.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "tb_lsu_mem_port global timeout");
  end

endmodule
